// File: rtl/tape_ram_loader_if.sv
// Signal bundle between the tape cache parser, the RAM write port and the loader.
// The slave side is the loader; the master side drives the parser and RAM-arbiter inputs.
interface tape_ram_loader_if;
  logic        tape_wr;
  logic [15:0] tape_addr;
  logic [7:0]  tape_dout;
  logic        tape_complete;
  logic        tape_autorun;
  logic [15:0] loadpoint;
  logic        ram_free;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        load_busy;
  logic        load_done;
  logic        autorun_req;
  logic [15:0] run_addr;
  logic [15:0] bytes_written;
  logic        tape_overflow;

  modport slave (
    input  tape_wr, tape_addr, tape_dout, tape_complete, tape_autorun, loadpoint, ram_free,
    output ram_we, ram_addr, ram_din, load_busy, load_done, autorun_req, run_addr,
           bytes_written, tape_overflow
  );

  modport master (
    output tape_wr, tape_addr, tape_dout, tape_complete, tape_autorun, loadpoint, ram_free,
    input  ram_we, ram_addr, ram_din, load_busy, load_done, autorun_req, run_addr,
           bytes_written, tape_overflow
  );
endinterface

// File: rtl/tape_ram_loader.sv
// Buffers parsed tape bytes in a small FIFO and writes them into RAM whenever the CPU
// leaves the port free, then signals completion and optionally requests autorun.
module tape_ram_loader #(
  parameter int FIFO_DEPTH   = 16,
  parameter int AUTORUN_HOLD = 1024
) (
  input logic              clk,
  input logic              reset_n,
  tape_ram_loader_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(AUTORUN_HOLD + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, AUTO} state_t;

  logic          rstMeta_q, rstSync_q;
  state_t        state_q, state_d;
  logic [AW:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [23:0]   mem_q [FIFO_DEPTH];
  logic [23:0]   head;
  logic          fifoEmpty, fifoFull, push, pop, drop;
  logic          pending_q, pending_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   runAddr_q, runAddr_d, bytes_q, bytes_d;
  logic          ovf_q, ovf_d, done_q, done_d;
  logic          busy_q, auto_q, we_q;
  logic [15:0]   ramAddr_q;
  logic [7:0]    ramDin_q;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rstMeta_q <= 1'b0;
      rstSync_q <= 1'b0;
    end else begin
      rstMeta_q <= 1'b1;
      rstSync_q <= rstMeta_q;
    end
  end

  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign pop       = bus.ram_free && !fifoEmpty;
  assign push      = bus.tape_wr && (!fifoFull || pop);
  assign drop      = bus.tape_wr && !push;
  assign head      = mem_q[rdPtr_q[AW-1:0]];
  assign wrPtr_d   = wrPtr_q + {{AW{1'b0}}, push};
  assign rdPtr_d   = rdPtr_q + {{AW{1'b0}}, pop};

  // When full, a simultaneous pop reads the old head before the new byte overwrites its slot.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q[AW-1:0]] <= {bus.tape_addr, bus.tape_dout};
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    runAddr_d = runAddr_q;
    bytes_d   = bytes_q;
    ovf_d     = ovf_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    if (state_q != AUTO && bus.tape_autorun) pending_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (bus.tape_wr || bus.tape_complete) begin
          if (bus.tape_wr) begin
            bytes_d = '0;
            ovf_d   = 1'b0;
          end
          if (bus.tape_complete) begin
            runAddr_d = bus.loadpoint;
            state_d   = DRAIN;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (bus.tape_complete) begin
          runAddr_d = bus.loadpoint;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (fifoEmpty) begin
          done_d  = 1'b1;
          hold_d  = '0;
          state_d = pending_q ? AUTO : IDLE;
        end
      end
      AUTO: begin
        if (hold_q == HW'(AUTORUN_HOLD - 1)) state_d = IDLE;
        else hold_d = hold_q + HW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE && state_q != IDLE) pending_d = 1'b0;
    if (pop) bytes_d = bytes_d + 16'd1;
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstSync_q) begin
    if (!rstSync_q) begin
      state_q   <= IDLE;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      pending_q <= 1'b0;
      hold_q    <= '0;
      runAddr_q <= '0;
      bytes_q   <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      auto_q    <= 1'b0;
      we_q      <= 1'b0;
      ramAddr_q <= '0;
      ramDin_q  <= '0;
    end else begin
      state_q   <= state_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
      runAddr_q <= runAddr_d;
      bytes_q   <= bytes_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      busy_q    <= (state_d == LOAD) || (state_d == DRAIN);
      auto_q    <= (state_d == AUTO);
      we_q      <= pop;
      if (pop) begin
        ramAddr_q <= head[23:8];
        ramDin_q  <= head[7:0];
      end
    end
  end

  assign bus.ram_we        = we_q;
  assign bus.ram_addr      = ramAddr_q;
  assign bus.ram_din       = ramDin_q;
  assign bus.load_busy     = busy_q;
  assign bus.load_done     = done_q;
  assign bus.autorun_req   = auto_q;
  assign bus.run_addr      = runAddr_q;
  assign bus.bytes_written = bytes_q;
  assign bus.tape_overflow = ovf_q;
endmodule

// File: tb/tb_tape_ram_loader.sv
// Directed bench for tape_ram_loader: a queue-based reference model is compared against
// every output on every falling edge, plus literal expectations for each scenario.
module tb_tape_ram_loader;
  localparam int DEPTH = 16;
  localparam int HOLD  = 1024;

  typedef enum {PH_IDLE, PH_LOAD, PH_DRAIN, PH_AUTO} phase_t;

  logic clk = 1'b0;
  logic rstN;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tape_ram_loader_if bus ();

  tape_ram_loader #(.FIFO_DEPTH(DEPTH), .AUTORUN_HOLD(HOLD)) dut (
    .clk     (clk),
    .reset_n (rstN),
    .bus     (bus)
  );

  phase_t      phase = PH_IDLE;
  logic [23:0] fifoQ[$];
  bit          pending = 1'b0;
  int          autoLeft = 0;
  int          syncEdges = 0;
  logic        mWe = 1'b0, mBusy = 1'b0, mDone = 1'b0, mAuto = 1'b0, mOvf = 1'b0;
  logic [15:0] mAddr = '0, mRun = '0, mBytes = '0;
  logic [7:0]  mDin = '0;

  logic [23:0] dutLog[$];
  int          donePulses = 0;
  int          autoCycles = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual 0x%0h, required 0x%0h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [60:0] dutOut();
    return {bus.ram_we, bus.ram_addr, bus.ram_din, bus.load_busy, bus.load_done,
            bus.autorun_req, bus.run_addr, bus.bytes_written, bus.tape_overflow};
  endfunction

  function automatic logic [60:0] modelOut();
    return {mWe, mAddr, mDin, mBusy, mDone, mAuto, mRun, mBytes, mOvf};
  endfunction

  task automatic modelReset();
    fifoQ.delete();
    phase = PH_IDLE;
    pending = 1'b0;
    autoLeft = 0;
    syncEdges = 0;
    {mWe, mBusy, mDone, mAuto, mOvf} = '0;
    {mAddr, mRun, mBytes, mDin} = '0;
  endtask

  // One clock edge of the loader's behaviour, expressed on a byte queue.
  task automatic modelStep();
    bit     wasEmpty, popNow, pushNow, oldPending;
    phase_t oldPhase;
    wasEmpty   = (fifoQ.size() == 0);
    popNow     = bus.ram_free && !wasEmpty;
    pushNow    = bus.tape_wr && (fifoQ.size() < DEPTH || popNow);
    oldPhase   = phase;
    oldPending = pending;
    mDone      = 1'b0;
    case (phase)
      PH_IDLE: if (bus.tape_wr || bus.tape_complete) begin
        if (bus.tape_wr) begin
          mBytes = '0;
          mOvf   = 1'b0;
        end
        if (bus.tape_complete) begin
          mRun  = bus.loadpoint;
          phase = PH_DRAIN;
        end else begin
          phase = PH_LOAD;
        end
      end
      PH_LOAD: if (bus.tape_complete) begin
        mRun  = bus.loadpoint;
        phase = PH_DRAIN;
      end
      PH_DRAIN: if (wasEmpty) begin
        mDone = 1'b1;
        if (oldPending) begin
          phase    = PH_AUTO;
          autoLeft = HOLD;
        end else begin
          phase = PH_IDLE;
        end
      end
      PH_AUTO: begin
        autoLeft--;
        if (autoLeft == 0) phase = PH_IDLE;
      end
      default: phase = PH_IDLE;
    endcase
    if (oldPhase != PH_AUTO && bus.tape_autorun) pending = 1'b1;
    if (phase == PH_IDLE && oldPhase != PH_IDLE) pending = 1'b0;
    mWe = popNow;
    if (popNow) begin
      {mAddr, mDin} = fifoQ.pop_front();
      mBytes = mBytes + 16'd1;
    end
    if (pushNow) fifoQ.push_back({bus.tape_addr, bus.tape_dout});
    else if (bus.tape_wr) mOvf = 1'b1;
    mBusy = (phase == PH_LOAD) || (phase == PH_DRAIN);
    mAuto = (phase == PH_AUTO);
  endtask

  always @(posedge clk or negedge rstN) begin
    if (!rstN) modelReset();
    else if (syncEdges < 2) syncEdges++;
    else modelStep();
  end

  always @(negedge clk) begin
    checkOutput("cycle_outputs", 64'(dutOut()), 64'(modelOut()));
    if (bus.ram_we) dutLog.push_back({bus.ram_addr, bus.ram_din});
    if (bus.load_done) donePulses++;
    if (bus.autorun_req) autoCycles++;
  end

  task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [7:0] dout,
                               input logic complete, input logic autorun, input logic free);
    bus.tape_wr       = wr;
    bus.tape_addr     = addr;
    bus.tape_dout     = dout;
    bus.tape_complete = complete;
    bus.tape_autorun  = autorun;
    bus.ram_free      = free;
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input int maxCycles, input logic free);
    int n;
    n = 0;
    while ((bus.load_busy || bus.autorun_req) && n < maxCycles) begin
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0, free);
      n++;
    end
    checkOutput("idle_within_bound", 64'(bus.load_busy | bus.autorun_req), 64'd0);
    repeat (2) applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0, free);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          logBase, doneBase, autoBase, bad;
    logic [15:0] ea;
    logic [7:0]  ed;
    rstN = 1'b0;
    bus.loadpoint = 16'h0;
    bus.tape_wr = 1'b0;
    bus.tape_addr = 16'h0;
    bus.tape_dout = 8'h0;
    bus.tape_complete = 1'b0;
    bus.tape_autorun = 1'b0;
    bus.ram_free = 1'b1;
    #1;
    checkOutput("reset_state", 64'(dutOut()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    repeat (2) applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1);

    $display("[TB] five-byte load with autorun");
    logBase = dutLog.size(); doneBase = donePulses; autoBase = autoCycles;
    bus.loadpoint = 16'h0501;
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 16'h0501 + 16'(i), 8'hA1 + 8'(i), i == 4, i == 4, 1'b1);
    waitIdle(1200, 1'b1);
    checkOutput("t1_write_count", 64'(dutLog.size() - logBase), 64'd5);
    for (int k = 0; k < 5; k++) begin
      ea = 16'h0501 + 16'(k);
      ed = 8'hA1 + 8'(k);
      checkOutput($sformatf("t1_write%0d", k), 64'(dutLog[logBase + k]), 64'({ea, ed}));
    end
    checkOutput("t1_bytes_written", 64'(bus.bytes_written), 64'd5);
    checkOutput("t1_done_pulses", 64'(donePulses - doneBase), 64'd1);
    checkOutput("t1_autorun_cycles", 64'(autoCycles - autoBase), 64'd1024);
    checkOutput("t1_run_addr", 64'(bus.run_addr), 64'h0501);

    $display("[TB] overflow with RAM port busy");
    logBase = dutLog.size(); doneBase = donePulses;
    bus.loadpoint = 16'h2000;
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 16'h2000 + 16'(i), 8'h10 + 8'(i), i == 19, 1'b0, 1'b0);
    repeat (20) applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_overflow_flag", 64'(bus.tape_overflow), 64'd1);
    checkOutput("t2_no_writes_while_busy", 64'(dutLog.size() - logBase), 64'd0);
    waitIdle(100, 1'b1);
    checkOutput("t2_write_count", 64'(dutLog.size() - logBase), 64'd16);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      ea = 16'h2000 + 16'(k);
      ed = 8'h10 + 8'(k);
      if (dutLog[logBase + k] !== {ea, ed}) bad++;
    end
    checkOutput("t2_write_order", 64'(bad), 64'd0);
    checkOutput("t2_bytes_written", 64'(bus.bytes_written), 64'd16);
    checkOutput("t2_overflow_sticky", 64'(bus.tape_overflow), 64'd1);
    checkOutput("t2_done_pulses", 64'(donePulses - doneBase), 64'd1);

    $display("[TB] push and pop together on a full FIFO");
    logBase = dutLog.size();
    bus.loadpoint = 16'h1000;
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 16'h1000 + 16'(i), 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 16; i < 100; i++) begin
      applyStimulus(1'b1, 16'h1000 + 16'(i), 8'(i), i == 99, 1'b0, 1'b1);
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    end
    waitIdle(200, 1'b1);
    checkOutput("t3_write_count", 64'(dutLog.size() - logBase), 64'd100);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      ea = 16'h1000 + 16'(k);
      ed = 8'(k);
      if (dutLog[logBase + k] !== {ea, ed}) bad++;
    end
    checkOutput("t3_write_order", 64'(bad), 64'd0);
    checkOutput("t3_no_overflow", 64'(bus.tape_overflow), 64'd0);
    checkOutput("t3_bytes_written", 64'(bus.bytes_written), 64'd100);

    $display("[TB] load without autorun");
    doneBase = donePulses; autoBase = autoCycles;
    bus.loadpoint = 16'h0400;
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 16'h0400 + 16'(i), 8'h55 + 8'(i), i == 2, 1'b0, 1'b1);
    waitIdle(50, 1'b1);
    checkOutput("t4_done_pulses", 64'(donePulses - doneBase), 64'd1);
    checkOutput("t4_no_autorun", 64'(autoCycles - autoBase), 64'd0);
    checkOutput("t4_run_addr", 64'(bus.run_addr), 64'h0400);
    checkOutput("t4_idle_busy", 64'(bus.load_busy), 64'd0);

    $display("[TB] reset in the middle of a load");
    bus.loadpoint = 16'h3000;
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 16'h0600 + 16'(i), 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
    rstN = 1'b0;
    #1;
    checkOutput("t5_async_reset_zero", 64'(dutOut()), 64'd0);
    repeat (2) applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    rstN = 1'b1;
    repeat (2) applyStimulus(1'b1, 16'h0EEE, 8'hEE, 1'b0, 1'b0, 1'b1);
    logBase = dutLog.size();
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 16'h3000 + 16'(i), 8'h40 + 8'(i), i == 3, 1'b0, 1'b1);
    waitIdle(50, 1'b1);
    checkOutput("t5_bytes_written", 64'(bus.bytes_written), 64'd4);
    checkOutput("t5_no_overflow", 64'(bus.tape_overflow), 64'd0);
    checkOutput("t5_write_count", 64'(dutLog.size() - logBase), 64'd4);
    checkOutput("t5_first_write", 64'(dutLog[logBase]), 64'h300040);

    $display("[TB] completion with no bytes");
    bus.loadpoint = 16'h0777;
    applyStimulus(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("t6_busy_after_first_edge", 64'(bus.load_busy), 64'd1);
    checkOutput("t6_no_done_first_edge", 64'(bus.load_done), 64'd0);
    applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("t6_done_second_edge", 64'(bus.load_done), 64'd1);
    checkOutput("t6_bytes_unchanged", 64'(bus.bytes_written), 64'd4);
    checkOutput("t6_run_addr", 64'(bus.run_addr), 64'h0777);
    applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("t6_back_to_idle", 64'({bus.load_busy, bus.load_done}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tape_ram_loader.md
TAPE_RAM_LOADER -- requirements
Module: tape_ram_loader

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, entries of {addr[15:0], data[7:0]}; power of two, at least 4.
REQ-002 Parameter AUTORUN_HOLD, default 1024, cycles that autorun_req is held high.
REQ-003 Ports, one per line (name, direction, width, meaning):
  clk  in  1  system clock; the only clock.
  reset_n  in  1  asynchronous, active-low reset.
  tape_wr  in  1  byte strobe from the tape cache parser; each cycle it is high is one byte.
  tape_addr  in  16  target RAM address of the byte.
  tape_dout  in  8  byte value.
  tape_complete  in  1  parser finished; may be high in the same cycle as the final tape_wr.
  tape_autorun  in  1  one-cycle autorun request from the parser.
  loadpoint  in  16  program start address.
  ram_free  in  1  high when the CPU is not using the RAM port this cycle.
  ram_we  out  1  RAM write enable.
  ram_addr  out  16  RAM write address.
  ram_din  out  8  RAM write data.
  load_busy  out  1  a load is in progress.
  load_done  out  1  one-cycle pulse when the load has fully landed in RAM.
  autorun_req  out  1  request to start the program.
  run_addr  out  16  start address to jump to.
  bytes_written  out  16  number of RAM writes in the current or last load.
  tape_overflow  out  1  sticky flag: a byte was dropped.

Function
REQ-004 All outputs and state are registered; there are no combinational paths from inputs to outputs.
REQ-005 The FIFO pushes {tape_addr, tape_dout} on each edge where tape_wr=1 and the FIFO is not full, or is full but a pop occurs on the same edge.
REQ-006 When tape_wr=1, the FIFO is full and no pop occurs, the byte is dropped and tape_overflow<=1.
REQ-007 On an edge where ram_free=1 and the FIFO is non-empty, the FIFO pops its head; ram_we<=1, ram_addr<=head addr, ram_din<=head data, and bytes_written increments (16-bit, wraps).
REQ-008 On all other edges, ram_we<=0; ram_addr and ram_din hold their values.
REQ-009 A pushed byte reaches ram_we no earlier than the second edge after the push; there is no bypass path.
REQ-010 The FIFO pointers are log2(FIFO_DEPTH) bits plus a wrap bit; full and empty are both correct across pointer wrap-around.
REQ-011 The FSM has four states: IDLE, LOAD, DRAIN, AUTO.
REQ-012 IDLE -> LOAD on tape_wr=1; on that edge bytes_written<=0 and tape_overflow<=0, and the byte is pushed per REQ-005.
REQ-013 In LOAD, tape_complete=1 latches the pending autorun flag from tape_autorun (see REQ-014), latches run_addr<=loadpoint, and moves to DRAIN.
REQ-014 tape_autorun is captured in any state except AUTO, into a pending flag that is cleared on entry to IDLE.
REQ-015 DRAIN -> AUTO when the FIFO is empty and no write is issued on that edge, with load_done<=1 for one cycle, if the pending autorun flag is set.
REQ-016 DRAIN -> IDLE under the same condition, with load_done<=1 for one cycle, if the pending autorun flag is clear.
REQ-017 AUTO holds autorun_req=1 for exactly AUTORUN_HOLD cycles, then goes to IDLE.
REQ-018 load_busy=1 in LOAD and DRAIN; load_busy=0 in IDLE and AUTO.
REQ-019 tape_wr=1 while in DRAIN or AUTO still pushes, and the state does not change; in AUTO the hold counter is unaffected.
REQ-020 tape_complete=1 in IDLE, with no prior tape_wr, leads through DRAIN with an empty FIFO; load_done pulses on the second edge and bytes_written is unchanged.

Reset
REQ-021 reset_n=0 asynchronously clears: FSM to IDLE, FIFO empty, ram_we, load_busy, load_done, autorun_req and tape_overflow to 0, and ram_addr, ram_din, run_addr and bytes_written to 0.
REQ-022 Reset asserted mid-load discards all buffered bytes; after release, the block ignores the input stream until the next tape_wr.
REQ-023 Reset deassertion is synchronised internally with a two-flop synchroniser; the first push is accepted on the third edge after release.

Verification
REQ-024 ram_free=1 constantly; 5 bytes 0xA1..0xA5 to 0x0501..0x0505, tape_complete with the last byte, tape_autorun=1, loadpoint=0x0501 -> 5 in-order writes, bytes_written=5, one load_done pulse, autorun_req high 1024 cycles, run_addr=0x0501.
REQ-025 ram_free=0 for 40 cycles; 20 bytes streamed -> first 16 buffered, 4 dropped, tape_overflow=1, and after ram_free=1 exactly 16 writes.
REQ-026 Simultaneous push and pop with the FIFO full, 100 bytes, ram_free toggling 1/0 -> no drop, writes in order, pointers wrap at least 6 times.
REQ-027 tape_autorun=0 with loadpoint=0x0400 -> load_done pulses, autorun_req stays 0, state returns to IDLE.
REQ-028 reset_n pulsed low after 3 of 10 bytes -> all outputs 0 immediately; a subsequent 4-byte load gives bytes_written=4 and tape_overflow=0.
